// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl
// Run/halt/single-step controller that produces the core clock enable.
// It supports free-running execution, N-cycle stepping, one PC breakpoint,
// and a counter of enabled cycles for performance measurement.
//
// Ports:
//   clk, rst           single clock; synchronous active-high reset
//   run_req            one-cycle request to free-run
//   halt_req           one-cycle request to stop
//   step_req           one-cycle request to run step_count enabled cycles
//   step_count         cycle count for a step, sampled when step_req is accepted
//   bp_en, bp_addr     breakpoint enable (level) and address
//   pc                 current core PC
//   cpu_en             core clock enable (combinational from pc)
//   state              HALT=00, RUN=01, STEP=10, BREAK=11
//   halted             state is HALT or BREAK
//   step_done          registered pulse when a step sequence completes
//   bp_hit             registered pulse on breakpoint entry
//   cycle_count        number of enabled cycles, wraps, cleared only by rst
module clk_run_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16,
  parameter int CYC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic [CNT_WIDTH-1:0] step_count,
  input  logic                 bp_en,
  input  logic [WIDTH-1:0]     bp_addr,
  input  logic [WIDTH-1:0]     pc,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 halted,
  output logic                 step_done,
  output logic                 bp_hit,
  output logic [CYC_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  state_t               cur_state;
  state_t               nxt_state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] remaining_nxt;
  logic                 bp_mask;
  logic                 bp_mask_nxt;
  logic                 bp_match;
  logic                 step_done_nxt;
  logic                 bp_hit_nxt;
  logic                 running;

  // The mask lets the core execute the instruction at bp_addr once after
  // resuming from BREAK; otherwise it would re-trap immediately.
  assign bp_match = bp_en & (pc == bp_addr) & ~bp_mask;
  assign running  = (cur_state == RUN) | (cur_state == STEP);
  // Combinational from pc so the instruction at bp_addr never executes.
  assign cpu_en   = running & ~bp_match;
  assign state    = cur_state;
  assign halted   = (cur_state == HALT) | (cur_state == BREAK);

  always_comb begin
    nxt_state     = cur_state;
    remaining_nxt = remaining;
    bp_mask_nxt   = bp_mask;
    step_done_nxt = 1'b0;
    bp_hit_nxt    = 1'b0;

    // The mask only covers the first enabled cycle after leaving BREAK.
    if (cpu_en) begin
      bp_mask_nxt = 1'b0;
    end

    unique case (cur_state)
      // In the stopped states bp_match is ignored: pc sits on bp_addr while
      // in BREAK, and a pending match must not block the resume request.
      HALT, BREAK: begin
        if (halt_req) begin
          nxt_state = HALT;
        end else if (step_req && (step_count != '0)) begin
          nxt_state     = STEP;
          remaining_nxt = step_count;
          if (cur_state == BREAK) begin
            bp_mask_nxt = 1'b1;
          end
        end else if (run_req) begin
          nxt_state = RUN;
          if (cur_state == BREAK) begin
            bp_mask_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        if (halt_req) begin
          nxt_state = HALT;
        end else if (bp_match) begin
          nxt_state  = BREAK;
          bp_hit_nxt = 1'b1;
        end
      end

      // Outside the halt/breakpoint branches cpu_en is necessarily 1,
      // so every remaining cycle in the else branch is an enabled cycle.
      STEP: begin
        if (halt_req) begin
          nxt_state     = HALT;
          remaining_nxt = '0;
        end else if (bp_match) begin
          nxt_state     = BREAK;
          bp_hit_nxt    = 1'b1;
          remaining_nxt = '0;
        end else if (remaining == CNT_WIDTH'(1)) begin
          nxt_state     = HALT;
          remaining_nxt = '0;
          step_done_nxt = 1'b1;
        end else begin
          remaining_nxt = remaining - CNT_WIDTH'(1);
        end
      end

      default: begin
        nxt_state = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= HALT;
      remaining   <= '0;
      bp_mask     <= 1'b0;
      step_done   <= 1'b0;
      bp_hit      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cur_state <= nxt_state;
      remaining <= remaining_nxt;
      bp_mask   <= bp_mask_nxt;
      step_done <= step_done_nxt;
      bp_hit    <= bp_hit_nxt;
      if (cpu_en) begin
        cycle_count <= cycle_count + CYC_WIDTH'(1);
      end
    end
  end

endmodule
